// File: rtl/des_subkey_if.sv
// Handshake bundle between the key source, the DES subkey scheduler and the round engine.
// The slave modport is the scheduler; the master modport is whoever loads keys and consumes subkeys.
interface des_subkey_if;
   logic        load;
   logic [63:0] key_in;
   logic        sk_ready;
   logic        sk_valid;
   logic [47:0] subkey;
   logic [3:0]  round_idx;
   logic        busy;
   logic        done;
   logic        key_err;

   modport master (
      output load, key_in, sk_ready,
      input  sk_valid, subkey, round_idx, busy, done, key_err
   );

   modport slave (
      input  load, key_in, sk_ready,
      output sk_valid, subkey, round_idx, busy, done, key_err
   );
endinterface

// File: rtl/des_subkey_sched.sv
// Sequential DES key schedule: emits the sixteen 48-bit round subkeys one per accepted handshake,
// K16..K1 with right rotations when DECRYPT=1, K1..K16 with left rotations when DECRYPT=0.
module des_subkey_sched #(
   parameter bit DECRYPT      = 1'b1,
   parameter bit CHECK_PARITY = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   des_subkey_if.slave  sk
);

   typedef enum logic {
      IDLE = 1'b0,
      GEN  = 1'b1
   } state_t;

   // Table entries use FIPS 46-3 numbering: bit 1 is the MSB of the source vector.
   localparam logic [6:0] PC1_TAB [56] = '{
      7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
      7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
      7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
      7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
      7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
      7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
      7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
      7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
   };

   localparam logic [5:0] PC2_TAB [48] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r[55 - i] = key[6'(7'd64 - PC1_TAB[i])];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         r[47 - i] = cd[6'(6'd56 - PC2_TAB[i])];
      end
      return r;
   endfunction

   // Rounds 1, 2, 9 and 16 shift by one position, all others by two.
   function automatic logic single_shift(input logic [4:0] rnd);
      return (rnd == 5'd1) || (rnd == 5'd2) || (rnd == 5'd9) || (rnd == 5'd16);
   endfunction

   function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   function automatic logic parity_bad(input logic [63:0] key);
      logic bad;
      bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (!(^key[b*8 +: 8])) bad = 1'b1;
      end
      return bad;
   endfunction

   state_t      state, state_nxt;
   logic [27:0] c_q, d_q, c_nxt, d_nxt;
   logic [3:0]  idx_q, idx_nxt;
   logic        valid_q, valid_nxt;
   logic        done_q, done_nxt;
   logic        err_q, err_nxt;

   logic [55:0] key_pc1;
   logic        last_sk;
   logic        step_one;

   assign key_pc1  = pc1(sk.key_in);
   assign last_sk  = DECRYPT ? (idx_q == 4'd0) : (idx_q == 4'd15);
   assign step_one = DECRYPT ? single_shift({1'b0, idx_q} + 5'd1)
                             : single_shift({1'b0, idx_q} + 5'd2);

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      c_nxt     = c_q;
      d_nxt     = d_q;
      idx_nxt   = idx_q;
      valid_nxt = valid_q;
      done_nxt  = 1'b0;
      err_nxt   = err_q;

      unique case (state)
         IDLE: begin
            if (sk.load) begin
               if (DECRYPT) begin
                  c_nxt   = key_pc1[55:28];
                  d_nxt   = key_pc1[27:0];
                  idx_nxt = 4'd15;
               end else begin
                  c_nxt   = rotl(key_pc1[55:28], 1'b1);
                  d_nxt   = rotl(key_pc1[27:0], 1'b1);
                  idx_nxt = 4'd0;
               end
               valid_nxt = 1'b1;
               err_nxt   = CHECK_PARITY && parity_bad(sk.key_in);
               state_nxt = GEN;
            end
         end
         GEN: begin
            if (valid_q && sk.sk_ready) begin
               if (last_sk) begin
                  valid_nxt = 1'b0;
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else if (DECRYPT) begin
                  c_nxt   = rotr(c_q, step_one);
                  d_nxt   = rotr(d_q, step_one);
                  idx_nxt = idx_q - 4'd1;
               end else begin
                  c_nxt   = rotl(c_q, step_one);
                  d_nxt   = rotl(d_q, step_one);
                  idx_nxt = idx_q + 4'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         c_q     <= c_nxt;
         d_q     <= d_nxt;
         idx_q   <= idx_nxt;
         valid_q <= valid_nxt;
         done_q  <= done_nxt;
         err_q   <= err_nxt;
      end
   end

   assign sk.subkey    = pc2({c_q, d_q});
   assign sk.sk_valid  = valid_q;
   assign sk.round_idx = idx_q;
   assign sk.busy      = (state == GEN);
   assign sk.done      = done_q;
   assign sk.key_err   = err_q;

endmodule

// File: tb/tb_des_subkey_sched.sv
// Directed bench for des_subkey_sched: decrypt, encrypt and parity-checking instances
// compared against the published subkeys of key 0x133457799BBCDFF1.
module tb_des_subkey_sched;

   localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;
   localparam logic [63:0] KEY_ALT = 64'h0123456789ABCDEF;

   // KS[i] is round subkey K(i+1) for KEY.
   localparam logic [47:0] KS [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   des_subkey_if d_if ();
   des_subkey_if e_if ();
   des_subkey_if p_if ();

   des_subkey_sched #(.DECRYPT(1'b1), .CHECK_PARITY(1'b0)) u_dec (.clk(clk), .rst(rst), .sk(d_if.slave));
   des_subkey_sched #(.DECRYPT(1'b0), .CHECK_PARITY(1'b0)) u_enc (.clk(clk), .rst(rst), .sk(e_if.slave));
   des_subkey_sched #(.DECRYPT(1'b1), .CHECK_PARITY(1'b1)) u_par (.clk(clk), .rst(rst), .sk(p_if.slave));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int cyc;
      logic r;

      rst = 1'b1;
      d_if.load = 1'b0; d_if.key_in = '0; d_if.sk_ready = 1'b0;
      e_if.load = 1'b0; e_if.key_in = '0; e_if.sk_ready = 1'b0;
      p_if.load = 1'b0; p_if.key_in = '0; p_if.sk_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_valid",  64'(d_if.sk_valid),  64'd0);
      check("rst_busy",   64'(d_if.busy),      64'd0);
      check("rst_done",   64'(d_if.done),      64'd0);
      check("rst_idx",    64'(d_if.round_idx), 64'd0);
      check("rst_subkey", 64'(d_if.subkey),    64'd0);
      check("rst_err",    64'(p_if.key_err),   64'd0);

      // Decrypt order, ready held high
      d_if.key_in = KEY; d_if.load = 1'b1; d_if.sk_ready = 1'b1;
      tick();
      d_if.load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("dec_valid",  64'(d_if.sk_valid),  64'd1);
         check("dec_busy",   64'(d_if.busy),      64'd1);
         check("dec_idx",    64'(d_if.round_idx), 64'(15 - i));
         check("dec_subkey", 64'(d_if.subkey),    64'(KS[15 - i]));
         check("dec_nodone", 64'(d_if.done),      64'd0);
         tick();
      end
      check("dec_done",      64'(d_if.done),     64'd1);
      check("dec_end_valid", 64'(d_if.sk_valid), 64'd0);
      check("dec_end_busy",  64'(d_if.busy),     64'd0);
      tick();
      check("dec_done_once", 64'(d_if.done),     64'd0);

      // Encrypt order, then a load in the done cycle
      e_if.key_in = KEY; e_if.load = 1'b1; e_if.sk_ready = 1'b1;
      tick();
      e_if.load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check("enc_idx",    64'(e_if.round_idx), 64'(i));
         check("enc_subkey", 64'(e_if.subkey),    64'(KS[i]));
         tick();
      end
      check("enc_done", 64'(e_if.done), 64'd1);
      e_if.key_in = KEY_BAD; e_if.load = 1'b1; e_if.sk_ready = 1'b0;
      tick();
      e_if.load = 1'b0;
      check("enc_reload_valid",  64'(e_if.sk_valid),  64'd1);
      check("enc_reload_idx",    64'(e_if.round_idx), 64'd0);
      check("enc_reload_subkey", 64'(e_if.subkey),    64'(KS[0]));
      check("enc_noparity_err",  64'(e_if.key_err),   64'd0);
      check("enc_reload_nodone", 64'(e_if.done),      64'd0);

      // Backpressure with a forced six-cycle stall
      d_if.key_in = KEY; d_if.load = 1'b1; d_if.sk_ready = 1'b0;
      tick();
      d_if.load = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 16 && cyc < 400) begin
         r = (cyc >= 4 && cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
         d_if.sk_ready = r;
         check("bp_valid",  64'(d_if.sk_valid),  64'd1);
         check("bp_idx",    64'(d_if.round_idx), 64'(15 - n));
         check("bp_subkey", 64'(d_if.subkey),    64'(KS[15 - n]));
         check("bp_nodone", 64'(d_if.done),      64'd0);
         tick();
         if (r) n++;
         cyc++;
      end
      check("bp_accepts", 64'(n), 64'd16);
      check("bp_done",    64'(d_if.done), 64'd1);
      d_if.sk_ready = 1'b0;
      tick();

      // Parity checking: good key, then a key with one even-parity byte
      p_if.key_in = KEY; p_if.load = 1'b1; p_if.sk_ready = 1'b1;
      tick();
      p_if.load = 1'b0;
      check("par_good_err", 64'(p_if.key_err), 64'd0);
      for (int i = 0; i < 16; i++) tick();
      check("par_good_done", 64'(p_if.done), 64'd1);
      p_if.key_in = KEY_BAD; p_if.load = 1'b1;
      tick();
      p_if.load = 1'b0;
      check("par_bad_err", 64'(p_if.key_err), 64'd1);
      for (int i = 0; i < 16; i++) begin
         check("par_bad_subkey", 64'(p_if.subkey), 64'(KS[15 - i]));
         tick();
      end
      check("par_bad_done",   64'(p_if.done),    64'd1);
      check("par_err_sticky", 64'(p_if.key_err), 64'd1);

      // Load while busy is ignored
      d_if.key_in = KEY; d_if.load = 1'b1; d_if.sk_ready = 1'b1;
      tick();
      d_if.load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      d_if.key_in = KEY_ALT; d_if.load = 1'b1; d_if.sk_ready = 1'b0;
      tick();
      d_if.load = 1'b0;
      check("ign_idx",    64'(d_if.round_idx), 64'd10);
      check("ign_subkey", 64'(d_if.subkey),    64'(KS[10]));
      check("ign_busy",   64'(d_if.busy),      64'd1);
      check("ign_err",    64'(d_if.key_err),   64'd0);
      d_if.sk_ready = 1'b1;
      for (int j = 10; j >= 0; j--) begin
         check("ign_rest_idx",    64'(d_if.round_idx), 64'(j));
         check("ign_rest_subkey", 64'(d_if.subkey),    64'(KS[j]));
         tick();
      end
      check("ign_done", 64'(d_if.done), 64'd1);
      tick();

      // Reset mid-schedule at round_idx 7
      d_if.key_in = KEY; d_if.load = 1'b1; d_if.sk_ready = 1'b1;
      tick();
      d_if.load = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("mid_idx", 64'(d_if.round_idx), 64'd7);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_valid",  64'(d_if.sk_valid),  64'd0);
      check("mid_rst_busy",   64'(d_if.busy),      64'd0);
      check("mid_rst_idx",    64'(d_if.round_idx), 64'd0);
      check("mid_rst_subkey", 64'(d_if.subkey),    64'd0);
      check("mid_rst_done",   64'(d_if.done),      64'd0);
      check("mid_rst_enc",    64'(e_if.sk_valid),  64'd0);
      tick();
      check("mid_rst_nodone", 64'(d_if.done),      64'd0);
      d_if.load = 1'b1;
      tick();
      d_if.load = 1'b0;
      check("restart_idx",    64'(d_if.round_idx), 64'd15);
      check("restart_subkey", 64'(d_if.subkey),    64'(KS[15]));
      tick();
      check("restart_idx2",    64'(d_if.round_idx), 64'd14);
      check("restart_subkey2", 64'(d_if.subkey),    64'(KS[14]));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
